// File: rtl/aec_tx.sv
// Token-to-ASCII expression sender for an external calculator: buffers a token expression,
// streams it as characters followed by '=', then captures the result or times out.
module aec_tx #(
    parameter int unsigned MAX_TOK = 15,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_valid,
    input  logic [4:0] tok_in,
    input  logic       tok_last,
    output logic       tok_ready,
    output logic [7:0] ascii_out,
    output logic       ready,
    input  logic       aec_valid,
    input  logic [6:0] aec_result,
    output logic       done,
    output logic [6:0] res_out,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CW = $clog2(MAX_TOK + 1);

    typedef enum logic [2:0] {StLoad, StSend, StEq, StWait, StDone, StGap} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [7:0]      tmr_q, tmr_d;
    logic [6:0]      res_q, res_d;
    logic            err_q, err_d;
    logic            wr_en;
    logic [4:0]      tok_buf_q [MAX_TOK];

    function automatic logic [7:0] to_ascii(input logic [4:0] code);
        logic [7:0] c;
        c = {3'b000, code};
        if (code < 5'd10) begin
            return 8'd48 + c;
        end else if (code < 5'd16) begin
            return 8'd87 + c;
        end
        case (code)
            5'd16:   return 8'd40;
            5'd17:   return 8'd41;
            5'd18:   return 8'd42;
            5'd19:   return 8'd43;
            default: return 8'd45;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        tmr_d     = tmr_q;
        res_d     = res_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        tok_ready = 1'b0;
        ascii_out = 8'd0;
        ready     = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StLoad: begin
                busy      = 1'b0;
                tok_ready = (count_q < CW'(MAX_TOK));
                if (tok_valid && tok_ready) begin
                    if (tok_in > 5'd20) begin
                        // Unknown codes are swallowed; an empty expression never starts.
                        err_d = 1'b1;
                        if (tok_last && count_q != '0) state_d = StSend;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        if (tok_last || count_d == CW'(MAX_TOK)) state_d = StSend;
                    end
                    if (state_d == StSend) begin
                        err_d = 1'b0;
                        idx_d = '0;
                    end
                end
            end
            StSend: begin
                ascii_out = to_ascii(tok_buf_q[idx_q]);
                ready     = (idx_q == '0);
                idx_d     = idx_q + CW'(1);
                if (idx_q == count_q - CW'(1)) state_d = StEq;
            end
            StEq: begin
                ascii_out = 8'd61;
                tmr_d     = 8'd0;
                state_d   = StWait;
            end
            StWait: begin
                if (aec_valid) begin
                    res_d   = aec_result;
                    state_d = StDone;
                end else if (tmr_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    res_d   = 7'd0;
                    state_d = StDone;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            StDone: begin
                done  = 1'b1;
                tmr_d = 8'd0;
                if (GAP == 0) begin
                    count_d = '0;
                    state_d = StLoad;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                tmr_d = tmr_q + 8'd1;
                if (tmr_q == 8'(GAP - 1)) begin
                    count_d = '0;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StLoad;
            count_q <= '0;
            idx_q   <= '0;
            tmr_q   <= 8'd0;
            res_q   <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Buffer contents are only ever read below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) tok_buf_q[count_q] <= tok_in;
    end

    assign res_out = res_q;
    assign err     = err_q;

endmodule

// File: doc/aec_tx.md
AEC_TX -- requirements
Module: aec_tx

Interface
REQ-001 SHALL have parameters: MAX_TOK, default 15, max tokens per expression; GAP, default 2, idle cycles after a result before the next load; TIMEOUT, default 255, max cycles to wait for aec_valid.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tok_valid  input  1  token offered.
REQ-005 SHALL have port tok_in  input  5  token code: 0-15 hex digit, 16 '(', 17 ')', 18 '*', 19 '+', 20 '-'.
REQ-006 SHALL have port tok_last  input  1  offered token ends the expression.
REQ-007 SHALL have port tok_ready  output  1  token accepted when tok_valid and tok_ready are both high.
REQ-008 SHALL have port ascii_out  output  8  character to the calculator.
REQ-009 SHALL have port ready  output  1  marks the first character of an expression.
REQ-010 SHALL have port aec_valid  input  1  calculator result strobe.
REQ-011 SHALL have port aec_result  input  7  calculator result.
REQ-012 SHALL have port done  output  1  one-cycle pulse when res_out is updated.
REQ-013 SHALL have port res_out  output  7  captured result.
REQ-014 SHALL have port busy  output  1  high in every state except LOAD.
REQ-015 SHALL have port err  output  1  sticky error flag, cleared on entry to SEND.

Function
REQ-016 SHALL implement states LOAD, SEND, EQ, WAIT, DONE, GAP.
REQ-017 LOAD: tok_ready SHALL be high while count < MAX_TOK; each accepted token is stored at index count, and count is incremented.
REQ-018 Token codes 21-31 SHALL be accepted and dropped (not stored, count unchanged), and SHALL set err.
REQ-019 Acceptance with tok_last, or acceptance that makes count equal MAX_TOK, SHALL move to SEND on the next edge; tok_ready SHALL be low outside LOAD.
REQ-020 tok_last on a dropped token with count 0 SHALL keep the block in LOAD.
REQ-021 SEND: exactly one character per cycle, in index order 0..count-1, with no gaps.
REQ-022 Mapping: codes 0-9 -> 48+code; 10-15 -> 97+(code-10); 16 -> 40; 17 -> 41; 18 -> 42; 19 -> 43; 20 -> 45.
REQ-023 ready SHALL be high only in the cycle carrying index 0, and low otherwise.
REQ-024 EQ: one cycle with ascii_out = 61 and ready = 0, then move to WAIT.
REQ-025 In LOAD, WAIT, DONE and GAP, ascii_out SHALL be 0; the value 61 SHALL never appear outside EQ.
REQ-026 The first character SHALL appear the cycle after the final token is accepted; total SEND+EQ length is count+1 cycles.
REQ-027 WAIT: an 8-bit counter SHALL start at 0.
REQ-028 In WAIT, aec_valid high SHALL capture aec_result into res_out and move to DONE.
REQ-029 In WAIT, reaching counter value TIMEOUT without aec_valid SHALL set err, load res_out = 0, and move to DONE.
REQ-030 aec_valid in any state other than WAIT SHALL be ignored.
REQ-031 DONE: done = 1 for one cycle, then move to GAP; res_out SHALL hold until the next DONE.
REQ-032 GAP: GAP cycles with all outputs idle, then clear count and move to LOAD.
REQ-033 The token buffer SHALL hold MAX_TOK entries of 5 bits; the index SHALL be 4 bits, with no wrap-around because acceptance stops at MAX_TOK.

Reset
REQ-034 rst low SHALL, asynchronously and from any state including mid-SEND, force: state LOAD, count 0, ascii_out 0, ready 0, done 0, res_out 0, err 0, busy 0.
REQ-035 After reset, tok_ready SHALL be 1 on the first cycle with rst high.
REQ-036 Stored tokens need no clearing, since count gates all reads.

Verification
REQ-037 Tokens 3, 19, 4 (last) -> ascii_out 51, 43, 52, 61 on consecutive cycles; ready high only with 51; then aec_valid with aec_result 7 -> done pulse, res_out 7.
REQ-038 Tokens 10, 18, 16, 2, 20, 1, 17 (last) -> 97, 42, 40, 50, 45, 49, 41, 61.
REQ-039 15 tokens of code 1 with no tok_last -> tok_ready drops after the 15th; fifteen 49s then 61.
REQ-040 Expression sent, aec_valid never asserted -> after 255 WAIT cycles err = 1, done pulse, res_out 0.
REQ-041 Token 25 offered in LOAD -> err = 1 and count unchanged; a following 5 (last) -> 53, 61.
REQ-042 rst low while the third character is on ascii_out -> ascii_out 0 and ready 0 immediately; tok_ready 1 after release; the next expression is sent normally.
